// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with per-operation
// signed/unsigned selection and a start/busy/done handshake.
module seq_mult #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  acc;
    logic              neg;
    logic [CW-1:0]     count;
    logic              last_step;

    logic [WIDTH-1:0]  mag1;
    logic [WIDTH-1:0]  mag2;
    logic [WIDTH:0]    sum;
    logic [2*WIDTH-1:0] prod_next;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits, so no extra magnitude bit is stored.
    always_comb begin
        mag1 = in1;
        mag2 = in2;
        if (signed_mode && in1[WIDTH-1]) mag1 = '0 - in1;
        if (signed_mode && in2[WIDTH-1]) mag2 = '0 - in2;
    end

    // One shift-add step: conditional add into the upper half, carry kept in
    // sum[WIDTH] and shifted down into the accumulator MSB.
    always_comb begin
        sum       = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
        prod_next = {sum, mplier[WIDTH-1:1]};
        last_step = (count == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and status decode from the registered state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch on acceptance, iteration in RUN, result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            count  <= '0;
            out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mag1;
                        mplier <= mag2;
                        neg    <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= prod_next[2*WIDTH-1:WIDTH];
                    mplier <= prod_next[WIDTH-1:0];
                    count  <= count + 1'b1;
                    if (last_step) out <= neg ? ('0 - prod_next) : prod_next;
                end
                default: ;
            endcase
        end
    end

endmodule
